// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity-mode codes
// matching the transmit side, baud divider constants and small helpers.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  // Parity-mode codes shared with the transmitter
  localparam logic [2:0] NO_CHECK  = 3'b000;
  localparam logic [2:0] ODD_CHECK = 3'b100;
  localparam logic [2:0] EVE_CHECK = 3'b110;

  localparam int OVS_RATE = 16;
  localparam int CNT_W    = 16;
  localparam int CLK_HZ   = 50_000_000;

  // clk cycles per oversample tick for a given baud, rounded to nearest
  function automatic int baud_div(input int baud);
    return (CLK_HZ + (OVS_RATE / 2) * baud) / (OVS_RATE * baud);
  endfunction

  localparam int B_RATE_2400   = baud_div(2400);
  localparam int B_RATE_4800   = baud_div(4800);
  localparam int B_RATE_9600   = baud_div(9600);
  localparam int B_RATE_19200  = baud_div(19200);
  localparam int B_RATE_38400  = baud_div(38400);
  localparam int B_RATE_57600  = baud_div(57600);
  localparam int B_RATE_115200 = baud_div(115200);
  localparam int B_RATE_230400 = baud_div(230400);
  localparam int B_RATE_460800 = baud_div(460800);
  localparam int B_RATE_921600 = baud_div(921600);

  // Map the receiver parameters onto the shared parity-mode code
  function automatic logic [2:0] parity_mode(input int par_en, input int par_odd);
    if (par_en == 0)
      return NO_CHECK;
    else if (par_odd != 0)
      return ODD_CHECK;
    else
      return EVE_CHECK;
  endfunction

  // Two-out-of-three vote used for mid-bit sampling
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_tick.sv
// Oversample tick generator: counts 0..OVS_DIV-1 and flags the last count.
// Restart re-phases the count to the detected start edge; disable parks it at 0.
module uart_rx_tick
  import uart_pkg::*;
#(
  parameter int OVS_DIV = 326
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic restart,
  output logic tick
);

  localparam logic [CNT_W-1:0] TC = CNT_W'(OVS_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // free-running divider, cleared on restart and held while disabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!en || restart) begin
      cnt <= '0;
    end else if (cnt == TC) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = en && !restart && (cnt == TC);

endmodule

// File: rtl/uart_rx_module.sv
// 16x oversampling UART receiver: 8 data bits LSB first, optional parity,
// 1 or 2 stop bits, one-entry holding register with ready/acknowledge,
// and single-cycle frame, parity and overrun pulses.
//
//   state  | meaning
//   IDLE   | line idle, waiting for a low level with the receiver enabled
//   START  | qualifying the start bit at mid-bit, false starts dropped
//   DATA   | shifting in eight data bits, LSB first
//   PARITY | checking the parity bit against the data
//   STOP   | checking stop bit(s); commit decision on the last one
module uart_rx_module
  import uart_pkg::*;
#(
  parameter int OVS_DIV    = B_RATE_9600,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       rx,
  input  logic       Rd,
  output logic [7:0] data_out,
  output logic       rx_ready,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun
);

  localparam logic [2:0] PAR_MODE  = parity_mode(PARITY_EN, PARITY_ODD);
  localparam logic       HAS_PAR   = (PAR_MODE != NO_CHECK);
  localparam logic       PAR_ODD   = (PAR_MODE == ODD_CHECK);
  localparam logic       LAST_STOP = (STOP_BITS == 2);

  logic      rx_meta;
  logic      rxs;
  logic      tick;
  logic      restart;
  rx_state_t state;
  logic [3:0] s_cnt;
  logic [2:0] bit_idx;
  logic      stop_idx;
  logic [1:0] smp;
  logic [7:0] shreg;
  logic      par_bad;
  logic      bit_val;

  // two-flop synchroniser; the line idles high so both flops reset to 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  // start detect; also re-phases the tick counter to the falling edge
  assign restart = (state == IDLE) && en && !rxs;

  uart_rx_tick #(
    .OVS_DIV (OVS_DIV)
  ) u_tick (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .restart (restart),
    .tick    (tick)
  );

  // samples at s_cnt 7 and 8 are stored; the third is the live line at 9
  assign bit_val = maj3(smp[0], smp[1], rxs);

  // frame FSM with registered data, ready level and error pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      s_cnt      <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      smp        <= '0;
      shreg      <= '0;
      par_bad    <= 1'b0;
      data_out   <= '0;
      rx_ready   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;

      if (Rd && rx_ready) begin
        rx_ready <= 1'b0;
      end

      if (!en) begin
        // abort silently; holding register left as is
        state <= IDLE;
        s_cnt <= '0;
      end else if (state == IDLE) begin
        if (!rxs) begin
          state    <= START;
          s_cnt    <= '0;
          bit_idx  <= '0;
          stop_idx <= 1'b0;
          par_bad  <= 1'b0;
        end
      end else if (tick) begin
        s_cnt <= s_cnt + 4'd1;
        if (s_cnt == 4'd7) smp[0] <= rxs;
        if (s_cnt == 4'd8) smp[1] <= rxs;

        case (state)
          START: begin
            if (s_cnt == 4'd9 && bit_val) begin
              state <= IDLE;
            end else if (s_cnt == 4'd15) begin
              state <= DATA;
            end
          end

          DATA: begin
            if (s_cnt == 4'd9) begin
              shreg <= {bit_val, shreg[7:1]};
            end else if (s_cnt == 4'd15) begin
              bit_idx <= bit_idx + 3'd1;
              if (bit_idx == 3'd7) begin
                state <= HAS_PAR ? PARITY : STOP;
              end
            end
          end

          PARITY: begin
            if (s_cnt == 4'd9) begin
              par_bad <= (^shreg) ^ bit_val ^ PAR_ODD;
            end else if (s_cnt == 4'd15) begin
              state <= STOP;
            end
          end

          STOP: begin
            if (s_cnt == 4'd9) begin
              if (!bit_val) begin
                // framing error wins over parity; line may still be low
                frame_err <= 1'b1;
                state     <= IDLE;
              end else if (stop_idx == LAST_STOP) begin
                // leave 6 ticks early so back-to-back frames are caught
                state <= IDLE;
                if (par_bad) begin
                  parity_err <= 1'b1;
                end else begin
                  data_out <= shreg;
                  rx_ready <= 1'b1;
                  if (rx_ready && !Rd) begin
                    overrun <= 1'b1;
                  end
                end
              end
            end else if (s_cnt == 4'd15) begin
              stop_idx <= 1'b1;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_module.sv
// Scoreboard bench: two receivers (8N1 and 8E2, OVS_DIV=4). Stimulus pushes
// the expected output event with its exact cycle; a monitor pops and compares
// whenever a receiver changes rx_ready/data_out or pulses an error flag.
module tb_uart_rx_module;

  localparam int BIT_CLK = 64;            // 16 ticks * OVS_DIV 4
  localparam int LAT8N1  = 3 + 4 * 154;   // line edge to commit edge, 8N1
  localparam int LAT8E2  = 3 + 4 * 186;   // 8 data, parity, 2 stop
  localparam int LAT8E2A = 3 + 4 * 170;   // first stop bit of 8E2

  typedef struct packed {
    logic       rdy;
    logic [7:0] data;
    logic       fe;
    logic       pe;
    logic       ov;
    int         at;
  } evt_t;

  logic       clk = 1'b0;
  logic       rst, en, rx, rd, rx_p, rd_p;
  logic [7:0] data_out, data_out_p;
  logic       rx_ready, frame_err, parity_err, overrun;
  logic       rx_ready_p, frame_err_p, parity_err_p, overrun_p;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   done = 1'b0;
  evt_t q[$];
  evt_t q_p[$];

  uart_rx_module #(.OVS_DIV(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut (
    .clk(clk), .rst(rst), .en(en), .rx(rx), .Rd(rd),
    .data_out(data_out), .rx_ready(rx_ready), .frame_err(frame_err),
    .parity_err(parity_err), .overrun(overrun)
  );

  uart_rx_module #(.OVS_DIV(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut_p (
    .clk(clk), .rst(rst), .en(en), .rx(rx_p), .Rd(rd_p),
    .data_out(data_out_p), .rx_ready(rx_ready_p), .frame_err(frame_err_p),
    .parity_err(parity_err_p), .overrun(overrun_p)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic evt_t mk(input logic r, input logic [7:0] d, input logic fe,
                              input logic pe, input logic ov, input int at);
    evt_t e;
    e.rdy = r; e.data = d; e.fe = fe; e.pe = pe; e.ov = ov; e.at = at;
    return e;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sel, input logic v);
    if (sel) rx_p = v; else rx = v;
    idle(BIT_CLK);
  endtask

  task automatic send(input bit sel, input logic [7:0] d, input bit has_par,
                      input logic par, input int nstop, input logic s0, input logic s1);
    drive(sel, 1'b0);
    for (int i = 0; i < 8; i++) drive(sel, d[i]);
    if (has_par) drive(sel, par);
    drive(sel, s0);
    if (nstop == 2) drive(sel, s1);
    if (sel) rx_p = 1'b1; else rx = 1'b1;
  endtask

  task automatic pulse_rd(input logic [7:0] d);
    rd = 1'b1;
    q.push_back(mk(1'b0, d, 1'b0, 1'b0, 1'b0, cyc + 1));
    idle(1);
    rd = 1'b0;
  endtask

  // monitor-side compare; the only place the counters are stepped
  task automatic score(input bit sel, input evt_t got);
    evt_t exp;
    bit   have;
    have = sel ? (q_p.size() > 0) : (q.size() > 0);
    checks++;
    if (!have) begin
      errors++;
      $display("FAIL %s unexpected_event got %p", sel ? "dut_p" : "dut", got);
    end else begin
      exp = sel ? q_p.pop_front() : q.pop_front();
      if (got !== exp) begin
        errors++;
        $display("FAIL %s event got %p want %p", sel ? "dut_p" : "dut", got, exp);
      end
    end
  endtask

  initial begin : monitor
    logic       pr, pr_p;
    logic [7:0] pd, pd_p;
    bit         rst_seen;
    pr = 1'b0; pr_p = 1'b0; pd = '0; pd_p = '0; rst_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (!rst_seen) begin
          rst_seen = 1'b1;
          checks++;
          if ({rx_ready, data_out, frame_err, parity_err, overrun} !== 12'h000) begin
            errors++;
            $display("FAIL dut reset_outputs got %b want 0",
                     {rx_ready, data_out, frame_err, parity_err, overrun});
          end
          checks++;
          if ({rx_ready_p, data_out_p, frame_err_p, parity_err_p, overrun_p} !== 12'h000) begin
            errors++;
            $display("FAIL dut_p reset_outputs got %b want 0",
                     {rx_ready_p, data_out_p, frame_err_p, parity_err_p, overrun_p});
          end
        end
      end else begin
        rst_seen = 1'b0;
        if (rx_ready !== pr || data_out !== pd || frame_err !== 1'b0 ||
            parity_err !== 1'b0 || overrun !== 1'b0)
          score(1'b0, mk(rx_ready, data_out, frame_err, parity_err, overrun, cyc));
        if (rx_ready_p !== pr_p || data_out_p !== pd_p || frame_err_p !== 1'b0 ||
            parity_err_p !== 1'b0 || overrun_p !== 1'b0)
          score(1'b1, mk(rx_ready_p, data_out_p, frame_err_p, parity_err_p, overrun_p, cyc));
      end
      pr = rx_ready; pd = data_out; pr_p = rx_ready_p; pd_p = data_out_p;
      if (done) begin
        checks++;
        if (q.size() != 0) begin
          errors++;
          $display("FAIL dut missing_events got %0d left want 0", q.size());
        end
        checks++;
        if (q_p.size() != 0) begin
          errors++;
          $display("FAIL dut_p missing_events got %0d left want 0", q_p.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
  end

  initial begin : watchdog
    #(60000 * 10);
    $display("FAIL watchdog timeout checks %0d errors %0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int s;
    int tgt;
    rst = 1'b1; en = 1'b1; rx = 1'b1; rx_p = 1'b1; rd = 1'b0; rd_p = 1'b0;
    idle(5);
    rst = 1'b0;
    idle(20);

    // 5-tick low glitch: false start, no output activity
    rx = 1'b0;
    idle(20);
    rx = 1'b1;
    idle(200);

    // 0xA5 8N1, then acknowledge
    s = cyc;
    q.push_back(mk(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, s + LAT8N1));
    send(1'b0, 8'hA5, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    idle(10);
    pulse_rd(8'hA5);
    idle(50);

    // 8E2: wrong parity bit on 0x3C (four ones, even parity bit should be 0)
    s = cyc;
    q_p.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, s + LAT8E2));
    send(1'b1, 8'h3C, 1'b1, 1'b1, 2, 1'b1, 1'b1);
    idle(100);
    // correct parity accepted
    s = cyc;
    q_p.push_back(mk(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, s + LAT8E2));
    send(1'b1, 8'h3C, 1'b1, 1'b0, 2, 1'b1, 1'b1);
    idle(100);
    // bad parity and low second stop: only frame_err
    s = cyc;
    q_p.push_back(mk(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, s + LAT8E2));
    send(1'b1, 8'h81, 1'b1, 1'b1, 2, 1'b1, 1'b0);
    idle(100);
    // low first stop: frame_err at the first stop bit
    s = cyc;
    q_p.push_back(mk(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, s + LAT8E2A));
    send(1'b1, 8'h81, 1'b1, 1'b0, 2, 1'b0, 1'b1);
    idle(100);

    // 0x55 with low stop, then 0x12 with no gap (re-detected 1 clk after frame_err)
    s = cyc;
    q.push_back(mk(1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, s + LAT8N1));
    q.push_back(mk(1'b1, 8'h12, 1'b0, 1'b0, 1'b0, s + LAT8N1 + 1 + 616));
    send(1'b0, 8'h55, 1'b0, 1'b0, 1, 1'b0, 1'b0);
    send(1'b0, 8'h12, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    idle(50);
    pulse_rd(8'h12);
    idle(20);

    // 0x01 then 0x02 without Rd: overrun on the second commit
    s = cyc;
    q.push_back(mk(1'b1, 8'h01, 1'b0, 1'b0, 1'b0, s + LAT8N1));
    q.push_back(mk(1'b1, 8'h02, 1'b0, 1'b0, 1'b1, s + BIT_CLK * 10 + LAT8N1));
    send(1'b0, 8'h01, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    send(1'b0, 8'h02, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    idle(50);
    pulse_rd(8'h02);
    idle(20);

    // repeat with Rd on the second commit cycle: no overrun, ready stays 1
    s = cyc;
    tgt = s + BIT_CLK * 10 + LAT8N1;
    q.push_back(mk(1'b1, 8'h01, 1'b0, 1'b0, 1'b0, s + LAT8N1));
    q.push_back(mk(1'b1, 8'h02, 1'b0, 1'b0, 1'b0, tgt));
    fork
      begin
        send(1'b0, 8'h01, 1'b0, 1'b0, 1, 1'b1, 1'b1);
        send(1'b0, 8'h02, 1'b0, 1'b0, 1, 1'b1, 1'b1);
      end
      begin
        while (cyc != tgt - 1) idle(1);
        rd = 1'b1;
        idle(1);
        rd = 1'b0;
      end
    join
    idle(50);

    // reset after data bit 3, then a clean 0xFF
    drive(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0);
    idle(10);
    rst = 1'b1;
    rx  = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(50);
    s = cyc;
    q.push_back(mk(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, s + LAT8N1));
    send(1'b0, 8'hFF, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    idle(50);

    // en dropped during data bit 4: frame abandoned, nothing reported
    fork
      send(1'b0, 8'h00, 1'b0, 1'b0, 1, 1'b1, 1'b1);
      begin
        idle(5 * BIT_CLK + 10);
        en = 1'b0;
        idle(400);
        en = 1'b1;
      end
    join
    idle(100);

    // receiver still works; 0xFF was never read, so this overruns
    s = cyc;
    q.push_back(mk(1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, s + LAT8N1));
    send(1'b0, 8'h5A, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    idle(100);

    done = 1'b1;
  end

endmodule

// File: doc/uart_rx_module.md
# uart_rx_module

Serial receiver forming the far-end counterpart of the design's UART transmit path: it oversamples the asynchronous `rx` line at 16x baud and deframes 8-bit characters, LSB first, with optional parity and 1 or 2 stop bits. Each good byte is placed in a one-entry holding register and flagged with a ready level, which the consumer acknowledges with `Rd`. The consumer is typically a FIFO or command parser. Frame, parity and overrun errors are reported as one-cycle pulses.

## Interface
- `OVS_DIV`, 326: clk cycles per oversample tick; baud = clk/(16*OVS_DIV); legal range 2..65535
- `PARITY_EN`, 0: 1 = a parity bit follows the data bits
- `PARITY_ODD`, 0: 1 = odd parity, 0 = even parity; ignored when `PARITY_EN`=0
- `STOP_BITS`, 1: 1 or 2
- `clk`  in  1  system clock; the block uses this single clock only
- `rst`  in  1  asynchronous, active-high reset
- `en`  in  1  receiver enable
- `rx`  in  1  serial line, asynchronous, idles high
- `Rd`  in  1  acknowledge; clears `rx_ready`
- `data_out`  out  8  last good byte received
- `rx_ready`  out  1  level; a byte is waiting in `data_out`
- `frame_err`  out  1  one-cycle pulse; a stop bit sampled low
- `parity_err`  out  1  one-cycle pulse; parity mismatch
- `overrun`  out  1  one-cycle pulse; a good byte arrived while `rx_ready` was already 1

## Operation
- Reset values:
  - outputs: `data_out`=0; `rx_ready`, `frame_err`, `parity_err`, `overrun` all 0
  - internal: both synchroniser flops = 1; tick counter = 0; FSM in IDLE
- `rx` passes through a 2-flop synchroniser; `rxs` denotes the synchronised value.
- Tick generator:
  - Counter runs 0..OVS_DIV-1 while `en`=1; `tick` is asserted when the count equals OVS_DIV-1.
  - The counter is cleared to 0 on start detect, so the bit phase is aligned to the detected edge.
  - The counter is held at 0 while `en`=0.
- The 4-bit `s_cnt` counts ticks within each bit (0..15). Each bit value is the majority of three samples taken at s_cnt 7, 8 and 9.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: when `rxs`=0 and `en`=1, go to START with s_cnt=0.
  - START: at s_cnt=9, a majority of 1 means a false start, so return to IDLE with no flag. Otherwise wait for s_cnt=15, then go to DATA.
  - DATA: at s_cnt=9, shift the majority bit in LSB first. After bit 7 at s_cnt=15, go to PARITY if `PARITY_EN`=1, otherwise go to STOP.
  - PARITY: at s_cnt=9, compute the error as (XOR of the 8 data bits, the parity bit, and `PARITY_ODD`) != 0. Go to STOP at s_cnt=15.
  - STOP: each stop bit is evaluated at s_cnt=9.
    - A 0 fires `frame_err` and returns to IDLE immediately, without waiting for the line to go high.
    - When `STOP_BITS`=2, the first stop bit runs to s_cnt=15 and the second bit is then checked the same way.
    - At s_cnt=9 of the final stop bit, the commit decision is made and the FSM returns to IDLE.
- Commit rules:
  - Parity error: fire `parity_err`; `data_out` and `rx_ready` are unchanged.
  - Frame error: `data_out` and `rx_ready` are unchanged. When both errors occur, only `frame_err` fires.
  - Good byte: `data_out` takes the new byte and `rx_ready` becomes 1. If `rx_ready` was already 1 and `Rd` is not asserted in the same cycle, `overrun` also pulses; the new byte overwrites the old one.
- `Rd` with `rx_ready`=1 clears `rx_ready` on the next cycle. If `Rd` coincides with a good-byte commit, `rx_ready` stays 1, `data_out` takes the new byte, and no overrun fires.
- `Rd` while `rx_ready`=0 is ignored.
- Dropping `en` mid-frame aborts to IDLE. No flag fires and the holding register is untouched.

## Timing
- Input latency: `rx` to `rxs` is 2 clk cycles.
- Commit timing: the decision occurs at tick N = (1 + 8 + PARITY_EN + STOP_BITS - 1)*16 + 10 after start detect, counting the first tick as 1.
- Outputs are registered: `rx_ready`, `data_out` and the error pulses change 1 clk cycle after the decision tick.
- Each error pulse is exactly 1 clk wide.
- Back-to-back frames are accepted: IDLE is re-entered 6 ticks before the nominal end of the stop bit, giving a tolerance of roughly ±3% baud mismatch.

## Structure
- Shared package `uart_pkg`:
  - FSM state encoding
  - Parity-mode constants matching the transmit side: NO_CHECK=3'b000, ODD_CHECK=3'b100, EVE_CHECK=3'b110
  - Baud factor constants B_RATE_2400..B_RATE_921600
- Sub-module `uart_rx_tick`: the tick counter, with inputs clk, rst, en and restart, and output tick.

## Test plan
All scenarios use OVS_DIV=4.
- 0xA5 sent 8N1 -> `rx_ready`=1 and `data_out`=8'hA5 one cycle after the decision tick; no error pulses; `Rd` clears `rx_ready` on the next cycle.
- A 5-tick low glitch on an idle line -> remains IDLE; all outputs stay 0.
- 0x3C sent with `PARITY_EN`=1, `PARITY_ODD`=0 and parity bit 1 (wrong) -> a single `parity_err` pulse; `rx_ready`=0 and `data_out` unchanged.
- 0x55 sent with the stop bit forced low -> `frame_err` pulse. A following 0x12 with no idle gap -> received correctly.
- Bytes 0x01 then 0x02 sent with no `Rd` -> `overrun` pulses on the second commit and `data_out`=8'h02. A repeat with `Rd` asserted on the commit cycle -> no overrun and `rx_ready`=1.
- `rst` asserted mid-byte (after data bit 3) -> all outputs 0 immediately. A subsequent 0xFF frame -> received cleanly.
